// File: rtl/register_unit.sv
// register_unit: RV32I architectural integer register file (x0..x31).
// Two combinational read ports, one synchronous write port, x0 reads zero.
module register_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_0400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  RuWr,
  input  logic [DATA_WIDTH-1:0] RuWrData,
  output logic [DATA_WIDTH-1:0] ru1,
  output logic [DATA_WIDTH-1:0] ru2
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;
  localparam int unsigned SP_IDX = 2;

  // Entry 0 exists only to keep indexing uniform; it is pinned to zero.
  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];

  // Next-state: at most one register (never x0) takes the writeback value.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (RuWr && (rd != '0)) begin
      regs_d[rd] = RuWrData;
    end
    regs_d[0] = '0;
  end

  // State register: synchronous reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: zero latency, no bypass; index 0 forced to zero even before reset.
  always_comb begin
    ru1 = (rs1 == '0) ? '0 : regs_q[rs1];
    ru2 = (rs2 == '0) ? '0 : regs_q[rs2];
  end

endmodule

// File: tb/tb_register_unit.sv
// tb_register_unit: self-checking bench for register_unit with a
// behavioural array model and directed plus randomized stimulus.
module tb_register_unit;

  localparam logic [31:0] SP = 32'h0000_0400;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        RuWr;
  logic [31:0] RuWrData;
  logic [31:0] ru1, ru2;

  int errors = 0;
  int checks = 0;

  // Reference model: plain array of architectural register values.
  logic [31:0] mdl [32];

  register_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .SP_INIT   (SP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .RuWr    (RuWr),
    .RuWrData(RuWrData),
    .ru1     (ru1),
    .ru2     (ru2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the current inputs to the model, then advance one rising edge.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = (i == 2) ? SP : 32'h0;
    end else if (RuWr && rd != 5'd0) begin
      mdl[rd] = RuWrData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; RuWr = 1'b0; rd = 5'd0; RuWrData = 32'h0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      checks++;
      if (ru1 !== ((i == 2) ? SP : 32'h0)) begin
        errors++;
        $display("FAIL reset_ru1 idx=%0d got=%h exp=%h", i, ru1, (i == 2) ? SP : 32'h0);
      end
      checks++;
      if (ru2 !== ((31 - i == 2) ? SP : 32'h0)) begin
        errors++;
        $display("FAIL reset_ru2 idx=%0d got=%h exp=%h", 31 - i, ru2, (31 - i == 2) ? SP : 32'h0);
      end
    end
  endtask

  task automatic test_write_read();
    rd = 5'd2; RuWr = 1'b1; RuWrData = 32'h12345678;
    tick();
    rd = 5'd1;
    tick();
    RuWr = 1'b0;
    rs1 = 5'd1; rs2 = 5'd2;
    #1;
    checks++;
    if (ru1 !== 32'h12345678) begin
      errors++; $display("FAIL wr_x1 got=%h exp=%h", ru1, 32'h12345678);
    end
    checks++;
    if (ru2 !== 32'h12345678) begin
      errors++; $display("FAIL wr_x2 got=%h exp=%h", ru2, 32'h12345678);
    end
    rs2 = 5'd3;
    #1;
    checks++;
    if (ru2 !== 32'h0) begin
      errors++; $display("FAIL wr_x3 got=%h exp=%h", ru2, 32'h0);
    end
    // Same register on both ports.
    rs1 = 5'd2; rs2 = 5'd2;
    #1;
    checks++;
    if (ru1 !== ru2 || ru1 !== 32'h12345678) begin
      errors++; $display("FAIL same_reg ru1=%h ru2=%h exp=%h", ru1, ru2, 32'h12345678);
    end
  endtask

  task automatic test_x0_write();
    rd = 5'd0; RuWr = 1'b1; RuWrData = 32'hFFFF_FFFF;
    tick();
    RuWr = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    checks++;
    if (ru1 !== 32'h0) begin
      errors++; $display("FAIL x0_ru1 got=%h exp=%h", ru1, 32'h0);
    end
    checks++;
    if (ru2 !== 32'h0) begin
      errors++; $display("FAIL x0_ru2 got=%h exp=%h", ru2, 32'h0);
    end
  endtask

  task automatic test_write_disable();
    RuWr = 1'b0; rd = 5'd5; RuWrData = 32'hDEAD_BEEF;
    repeat (4) tick();
    rs1 = 5'd5; rs2 = 5'd1;
    #1;
    checks++;
    if (ru1 !== 32'h0) begin
      errors++; $display("FAIL nowr_x5 got=%h exp=%h", ru1, 32'h0);
    end
    checks++;
    if (ru2 !== 32'h12345678) begin
      errors++; $display("FAIL nowr_x1 got=%h exp=%h", ru2, 32'h12345678);
    end
  endtask

  task automatic test_no_bypass();
    rs1 = 5'd7; rd = 5'd7; RuWr = 1'b1; RuWrData = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (ru1 !== 32'h0) begin
      errors++; $display("FAIL bypass_before got=%h exp=%h", ru1, 32'h0);
    end
    tick();
    RuWr = 1'b0;
    #1;
    checks++;
    if (ru1 !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL bypass_after got=%h exp=%h", ru1, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_reset_priority();
    rs1 = 5'd1; rs2 = 5'd7;
    #1;
    checks++;
    if (ru1 !== 32'h12345678) begin
      errors++; $display("FAIL prio_pre_x1 got=%h exp=%h", ru1, 32'h12345678);
    end
    rst = 1'b1; RuWr = 1'b1; rd = 5'd1; RuWrData = 32'h1;
    tick();
    rst = 1'b0; RuWr = 1'b0;
    #1;
    checks++;
    if (ru1 !== 32'h0) begin
      errors++; $display("FAIL prio_x1 got=%h exp=%h", ru1, 32'h0);
    end
    checks++;
    if (ru2 !== 32'h0) begin
      errors++; $display("FAIL prio_x7 got=%h exp=%h", ru2, 32'h0);
    end
    rs2 = 5'd2;
    #1;
    checks++;
    if (ru2 !== SP) begin
      errors++; $display("FAIL prio_x2 got=%h exp=%h", ru2, SP);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      RuWr     = 1'($urandom_range(0, 3) != 0);
      rd       = 5'($urandom_range(0, 31));
      RuWrData = $urandom;
      rs1      = 5'($urandom_range(0, 31));
      rs2      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (ru1 !== mdl[rs1]) begin
        errors++; $display("FAIL rand_ru1 n=%0d rs1=%0d got=%h exp=%h", n, rs1, ru1, mdl[rs1]);
      end
      checks++;
      if (ru2 !== mdl[rs2]) begin
        errors++; $display("FAIL rand_ru2 n=%0d rs2=%0d got=%h exp=%h", n, rs2, ru2, mdl[rs2]);
      end
      tick();
    end
    rst = 1'b0; RuWr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      #1;
      checks++;
      if (ru1 !== mdl[i]) begin
        errors++; $display("FAIL rand_final idx=%0d got=%h exp=%h", i, ru1, mdl[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; RuWr = 1'b0; rd = 5'd0; RuWrData = 32'h0;
    rs1 = 5'd0; rs2 = 5'd0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    #2;
    // x0 reads zero even before any reset edge.
    checks++;
    if (ru1 !== 32'h0) begin
      errors++; $display("FAIL prereset_x0 got=%h exp=%h", ru1, 32'h0);
    end
    test_reset();
    test_write_read();
    test_x0_write();
    test_write_disable();
    test_no_bypass();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
